// File: rtl/dense_mac_pkg.sv
// Shared types and constants for the dense MAC layer: FSM encoding, default widths
// and the output-major weight indexing helper.
package dense_mac_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_ACC_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_W = 2'd1,
        ST_MAC    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Flat weight element for neuron o, input i.
    function automatic int slice_idx(input int o, input int i, input int in_size);
        return o * in_size + i;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One neuron lane: registered signed WxW product feeding an ACC_W wrapping accumulator.
// Product lands one cycle after i_mul_en; o_sum is the accumulator plus the held product.
module mac_lane
    import dense_mac_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_mul_en,
    input  logic             i_acc_en,
    input  logic [W-1:0]     i_wt,
    input  logic [W-1:0]     i_act,
    output logic [ACC_W-1:0] o_sum
);

    logic signed [2*W-1:0]   w_wt_ext;
    logic signed [2*W-1:0]   w_act_ext;
    logic signed [2*W-1:0]   w_prod;
    logic [ACC_W-1:0]        w_prod_ext;
    logic [2*W-1:0]          r_prod;
    logic [ACC_W-1:0]        r_acc;

    assign w_wt_ext   = {{W{i_wt[W-1]}}, i_wt};
    assign w_act_ext  = {{W{i_act[W-1]}}, i_act};
    assign w_prod     = w_wt_ext * w_act_ext;
    assign w_prod_ext = {{(ACC_W-2*W){r_prod[2*W-1]}}, r_prod};
    assign o_sum      = r_acc + w_prod_ext;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            if (i_mul_en) begin
                r_prod <= w_prod;
            end
            if (i_acc_en) begin
                r_acc <= o_sum;
            end
        end
    end

endmodule

// File: rtl/dense_mac_layer1.sv
// Dense layer: OUT_SIZE parallel lanes walk IN_SIZE inputs; done IN_SIZE+1 cycles after accept.
// No backpressure; waits in WAIT_W for weights_valid. Optional DENSE_MAC_RELU_EN clamps negatives.
module dense_mac_layer1
    import dense_mac_pkg::*;
#(
    parameter int IN_SIZE       = 1152,
    parameter int OUT_SIZE      = 8,
    parameter int W             = DEF_W,
    parameter int ACC_W         = DEF_ACC_W,
    parameter int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      weights_valid,
    input  logic [TOTAL_WEIGHTS*W-1:0] weights,
    input  logic [IN_SIZE*W-1:0]      act_in,
    output logic [OUT_SIZE*ACC_W-1:0] data_out,
    output logic                      busy,
    output logic                      done
);

    localparam int IDX_W = $clog2(IN_SIZE + 1);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [IDX_W-1:0]               r_idx;
    logic [IDX_W-1:0]               w_sel_idx;
    logic                           r_pvld;
    logic                           r_plast;
    logic                           w_enter_mac;
    logic                           w_issue;
    logic                           w_final;
    logic [OUT_SIZE-1:0][ACC_W-1:0] w_sum;
    logic [OUT_SIZE-1:0][ACC_W-1:0] w_res;
    logic [OUT_SIZE*ACC_W-1:0]      r_data_out;

    // The product stage adds one cycle: idx issues products, r_pvld/r_plast track the add.
    assign w_issue   = (r_state == ST_MAC) && (r_idx != IDX_W'(IN_SIZE));
    assign w_final   = (r_state == ST_MAC) && r_pvld && r_plast;
    assign w_sel_idx = w_issue ? r_idx : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_enter_mac = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (weights_valid) begin
                        w_state_nxt = ST_MAC;
                        w_enter_mac = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_W;
                    end
                end
            end
            ST_WAIT_W: begin
                if (weights_valid) begin
                    w_state_nxt = ST_MAC;
                    w_enter_mac = 1'b1;
                end
            end
            ST_MAC: begin
                if (w_final) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_enter_mac) begin
            r_idx   <= '0;
            r_pvld  <= 1'b0;
            r_plast <= 1'b0;
        end else if (r_state == ST_MAC) begin
            r_pvld  <= w_issue;
            r_plast <= w_issue && (r_idx == IDX_W'(IN_SIZE - 1));
            if (w_issue) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    for (genvar o = 0; o < OUT_SIZE; o++) begin : g_lane
        mac_lane #(
            .W     (W),
            .ACC_W (ACC_W)
        ) u_lane (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_clr    (w_enter_mac),
            .i_mul_en (w_issue),
            .i_acc_en (r_pvld),
            .i_wt     (weights[slice_idx(o, int'(w_sel_idx), IN_SIZE)*W +: W]),
            .i_act    (act_in[int'(w_sel_idx)*W +: W]),
            .o_sum    (w_sum[o])
        );

`ifdef DENSE_MAC_RELU_EN
        assign w_res[o] = w_sum[o][ACC_W-1] ? '0 : w_sum[o];
`else
        assign w_res[o] = w_sum[o];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else if (w_final) begin
            for (int o = 0; o < OUT_SIZE; o++) begin
                r_data_out[o*ACC_W +: ACC_W] <= w_res[o];
            end
        end
    end

    assign data_out = r_data_out;
    assign busy     = (r_state == ST_WAIT_W) || (r_state == ST_MAC);
    assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_dense_mac_layer1.sv
// Directed bench for dense_mac_layer1 at IN_SIZE=4, OUT_SIZE=2, W=8, ACC_W=32.
module tb_dense_mac_layer1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        weights_valid;
    logic [63:0] weights;
    logic [31:0] act_in;
    logic [63:0] data_out;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

`ifdef DENSE_MAC_RELU_EN
    localparam logic signed [31:0] EXP_NEG = 32'sd0;
`else
    localparam logic signed [31:0] EXP_NEG = -32'sd65024;
`endif

    always #5 clk = ~clk;

    dense_mac_layer1 #(
        .IN_SIZE       (4),
        .OUT_SIZE      (2),
        .W             (8),
        .ACC_W         (32),
        .TOTAL_WEIGHTS (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .weights_valid (weights_valid),
        .weights       (weights),
        .act_in        (act_in),
        .data_out      (data_out),
        .busy          (busy),
        .done          (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_act(input int a0, input int a1, input int a2, input int a3);
        act_in = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endtask

    // w0..w3 feed neuron 0, w4..w7 feed neuron 1.
    task automatic set_w(input int w0, input int w1, input int w2, input int w3,
                         input int w4, input int w5, input int w6, input int w7);
        weights = {8'(w7), 8'(w6), 8'(w5), 8'(w4), 8'(w3), 8'(w2), 8'(w1), 8'(w0)};
    endtask

    function automatic logic signed [31:0] out_val(input int o);
        return data_out[o*32 +: 32];
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_run(input string name, input int cyc,
                             input logic signed [31:0] e0, input logic signed [31:0] e1);
        n_vec++;
        if (cyc !== 5) begin
            n_err++;
            $display("FAIL %s_latency: got %0d cycles, expected 5", name, cyc);
        end
        n_vec++;
        if (out_val(0) !== e0) begin
            n_err++;
            $display("FAIL %s_out0: got %0d, expected %0d", name, out_val(0), e0);
        end
        n_vec++;
        if (out_val(1) !== e1) begin
            n_err++;
            $display("FAIL %s_out1: got %0d, expected %0d", name, out_val(1), e1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        weights_valid = 1'b0;
        set_act(0, 0, 0, 0);
        set_w(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done: got %b, expected 0", done);
        end
        n_vec++;
        if (data_out !== 64'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h, expected 0", data_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int c;
        set_act(1, 2, 3, 4);
        set_w(1, 1, 1, 1, -1, 0, 2, 5);
        weights_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy: got %b, expected 1", busy);
        end
        n_vec++;
        if (data_out !== 64'd0) begin
            n_err++;
            $display("FAIL basic_data_early: got %h, expected 0", data_out);
        end
        wait_done(c);
        check_run("basic", c, 32'sd10, 32'sd25);
        tick();
        tick();
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || out_val(0) !== 32'sd10) begin
            n_err++;
            $display("FAIL basic_hold: done=%b busy=%b out0=%0d, expected 1 0 10",
                     done, busy, out_val(0));
        end
    endtask

    task automatic test_extremes();
        int c;
        set_act(-128, -128, -128, -128);
        set_w(-128, -128, -128, -128, 127, 127, 127, 127);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(c);
        check_run("extremes", c, 32'sd65536, EXP_NEG);
    endtask

    task automatic test_wait_w();
        int c;
        set_act(2, 0, -1, 3);
        set_w(1, 1, 1, 1, -1, 0, 2, 5);
        weights_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL waitw_hold%0d: busy=%b done=%b, expected 1 0", i, busy, done);
            end
            if (i < 2) tick();
        end
        weights_valid = 1'b1;
        tick();
        c = 0;
        while (done !== 1'b1 && c < 20) begin
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL waitw_busy%0d: got %b, expected 1", c, busy);
            end
            tick();
            c++;
        end
        check_run("waitw", c, 32'sd4, 32'sd11);
    endtask

    task automatic test_reset_mid();
        int c;
        set_act(1, 2, 3, 4);
        set_w(1, 1, 1, 1, -1, 0, 2, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_ctrl: busy=%b done=%b, expected 0 0", busy, done);
        end
        n_vec++;
        if (data_out !== 64'd0) begin
            n_err++;
            $display("FAIL rstmid_data: got %h, expected 0", data_out);
        end
        tick();
        tick();
        n_vec++;
        if (done !== 1'b0 || data_out !== 64'd0) begin
            n_err++;
            $display("FAIL rstmid_idle: done=%b data=%h, expected 0 0", done, data_out);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(c);
        check_run("rstmid_rerun", c, 32'sd10, 32'sd25);
    endtask

    task automatic test_back_to_back();
        int c;
        set_act(0, 0, 0, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done_drop: got %b, expected 0", done);
        end
        n_vec++;
        if (out_val(0) !== 32'sd10) begin
            n_err++;
            $display("FAIL b2b_data_hold: got %0d, expected 10", out_val(0));
        end
        c = 0;
        while (done !== 1'b1 && c < 20) begin
            start = (c == 1 || c == 3);
            tick();
            c++;
        end
        start = 1'b0;
        check_run("b2b", c, 32'sd1, 32'sd5);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_wait_w();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dense_mac_layer1.md
DENSE_MAC_LAYER1 -- requirements
Module: dense_mac_layer1

Interface
REQ-001 Parameter IN_SIZE, default 1152: number of input activations.
REQ-002 Parameter OUT_SIZE, default 8: number of output neurons.
REQ-003 Parameter W, default 8: signed weight and activation width.
REQ-004 Parameter ACC_W, default 32: signed accumulator and result width.
REQ-005 Parameter TOTAL_WEIGHTS, default IN_SIZE*OUT_SIZE: flat weight count.
REQ-006 clk  input  1: system clock; one clock; all state changes on posedge clk.
REQ-007 rst_n  input  1: reset, synchronous, active-low.
REQ-008 start  input  1: request one layer evaluation.
REQ-009 weights_valid  input  1: upstream weight loader done; weights vector stable.
REQ-010 weights  input  TOTAL_WEIGHTS*W: flat weights; element k at [k*W +: W]; k = o*IN_SIZE + i (output-major).
REQ-011 act_in  input  IN_SIZE*W: flat signed activations; element i at [i*W +: W].
REQ-012 data_out  output  OUT_SIZE*ACC_W: neuron results; neuron o at [o*ACC_W +: ACC_W].
REQ-013 busy  output  1: high in WAIT_W and MAC states.
REQ-014 done  output  1: high in DONE state.

Function
REQ-015 States: IDLE, WAIT_W, MAC, DONE.
REQ-016 IDLE: start=1 and weights_valid=1 -> MAC; start=1 and weights_valid=0 -> WAIT_W; otherwise stay.
REQ-017 WAIT_W: weights_valid=1 -> MAC; start is ignored.
REQ-018 Entering MAC: clear all OUT_SIZE accumulators to 0; set index idx to 0.
REQ-019 MAC: each cycle, for every o in parallel, acc[o] += sext(weights[o*IN_SIZE+idx]) * sext(act_in[idx]); then idx increments.
REQ-020 Product width: 2*W signed, sign-extended to ACC_W; accumulation wraps in two's complement with no saturation.
REQ-021 MAC with idx==IN_SIZE-1: perform the final add; load data_out with the final sums; go to DONE.
REQ-022 Latency: start sampled in IDLE with weights_valid=1 at edge N; done=1 after edge N+IN_SIZE+1.
REQ-023 DONE: done holds and data_out holds until start=1 is sampled, which follows the same rules as IDLE (back-to-back runs).
REQ-024 start during MAC is ignored; a weights_valid drop during MAC is ignored.
REQ-025 Upstream holds weights and act_in stable from acceptance through DONE; data_out changes only at the REQ-021 load.

Reset
REQ-026 rst_n=0 at a clock edge: state IDLE, idx 0, accumulators 0, data_out 0, busy 0, done 0.
REQ-027 Reset asserted mid-MAC or mid-WAIT_W aborts the run; no partial result reaches data_out.

Configuration
REQ-028 Macro DENSE_MAC_RELU_EN defined: at the REQ-021 load, each negative sum is stored as 0; non-negative sums are unchanged.
REQ-029 DENSE_MAC_RELU_EN undefined: raw signed sums are stored; no ReLU logic is present.

Structure
REQ-030 Package dense_mac_pkg: state encoding typedef, default W/ACC_W constants, helper for weight-slice index o*IN_SIZE+i.
REQ-031 Sub-module mac_lane: one signed W x W multiply plus ACC_W accumulator with clear/enable; instantiated OUT_SIZE times via generate.

Verification (bench with IN_SIZE=4, OUT_SIZE=2, W=8, ACC_W=32)
REQ-032 act=[1,2,3,4], w0=[1,1,1,1], w1=[-1,0,2,5], start with weights_valid=1 -> done 5 cycles later; out0=10, out1=25.
REQ-033 act=[-128]*4, w0=[-128]*4, w1=[127]*4 -> out0=65536; out1=-65024 (0 with DENSE_MAC_RELU_EN).
REQ-034 start with weights_valid=0 for 3 cycles, then weights_valid=1 -> busy=1 throughout; done exactly IN_SIZE+1 cycles after the weights_valid edge.
REQ-035 rst_n=0 at MAC cycle 2 -> next cycle: state IDLE, data_out=0, done=0; a following run gives correct sums.
REQ-036 Second start in DONE with new act=[0,0,0,1] -> done drops, re-asserts after 5 cycles; out0=1, out1=5; start pulses during MAC have no effect.
